// File: rtl/spi_reg_peri_if.sv
// SPI pad bundle for spi_reg_peri: SCLK/CS/MOSI from the bus master,
// single-bit MISO plus the quad data lines and their enables back.
interface spi_reg_peri_if;
    logic       spi_clk;
    logic       spi_select;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] spi_q_data_out;
    logic [3:0] spi_q_oe;

    modport master (
        output spi_clk, spi_select, spi_mosi,
        input  spi_miso, spi_q_data_out, spi_q_oe
    );

    modport slave (
        input  spi_clk, spi_select, spi_mosi,
        output spi_miso, spi_q_data_out, spi_q_oe
    );
endinterface

// File: rtl/spi_reg_peri.sv
// SPI-slave register file: oversampled mode-0 bus, 8-bit command + address,
// auto-incrementing burst write / single read / quad read, registered debug tap.
module spi_reg_peri #(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_W     = 4,
    parameter int QUAD_DUMMY = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_reg_peri_if.slave       bus,
    input  logic [ADDR_W-1:0]   debug_addr,
    output logic [DATA_W-1:0]   debug_data,
    output logic                wr_strobe,
    output logic [ADDR_W-1:0]   wr_addr
);
    localparam int         IW       = $clog2(NUM_REGS);
    localparam logic [7:0] LAST_PTR = 8'(NUM_REGS - 1);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || NUM_REGS < 2 ||
        NUM_REGS > 256 || ADDR_W < IW) begin : g_bad_params
        $error("spi_reg_peri: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WRITE, S_READ, S_QREAD, S_IGNORE
    } state_t;
    typedef enum logic [1:0] {M_WR, M_RD, M_QRD} mode_t;

    logic [2:0] sclk_s;
    logic [1:0] sel_s, mosi_s;
    logic       rise, fall, desel, mosi;

    state_t                      state, state_nxt;
    mode_t                       mode, mode_nxt;
    logic [7:0]                  bit_cnt, cnt_nxt;
    logic [7:0]                  ptr, ptr_nxt;
    logic [DATA_W-1:0]           rx_sh, rx_nxt, rx_word;
    logic [DATA_W-1:0]           tx_sh, tx_nxt;
    logic                        miso_r, miso_nxt;
    logic [3:0]                  qd_r, qd_nxt, q_oe_r;
    logic                        commit, need_desel;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // Synchronisers are left free-running so reset can see whether the bus is mid-frame.
    always_ff @(posedge clk) begin
        sclk_s <= {sclk_s[1:0], bus.spi_clk};
        sel_s  <= {sel_s[0], bus.spi_select};
        mosi_s <= {mosi_s[0], bus.spi_mosi};
    end

    assign rise    = sclk_s[1] & ~sclk_s[2];
    assign fall    = ~sclk_s[1] & sclk_s[2];
    assign desel   = sel_s[1];
    assign mosi    = mosi_s[1];
    assign rx_word = {rx_sh[DATA_W-2:0], mosi};

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == LAST_PTR) ? 8'd0 : p + 8'd1;
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [7:0] p);
        if (32'(p) < 32'(NUM_REGS)) return regs[p[IW-1:0]];
        return '0;
    endfunction

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        cnt_nxt   = bit_cnt;
        ptr_nxt   = ptr;
        rx_nxt    = rx_sh;
        tx_nxt    = tx_sh;
        miso_nxt  = miso_r;
        qd_nxt    = qd_r;
        commit    = 1'b0;
        if (desel) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                S_IDLE: if (!need_desel) begin
                    state_nxt = S_CMD;
                    cnt_nxt   = '0;
                end
                S_CMD: if (rise) begin
                    rx_nxt  = rx_word;
                    cnt_nxt = bit_cnt + 8'd1;
                    if (bit_cnt == 8'd7) begin
                        cnt_nxt   = '0;
                        state_nxt = S_ADDR;
                        case (rx_word[7:0])
                            8'h02:   mode_nxt = M_WR;
                            8'h03:   mode_nxt = M_RD;
                            8'h6B:   mode_nxt = M_QRD;
                            default: state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: if (rise) begin
                    rx_nxt  = rx_word;
                    cnt_nxt = bit_cnt + 8'd1;
                    if (bit_cnt == 8'd7) begin
                        cnt_nxt = '0;
                        ptr_nxt = rx_word[7:0];
                        case (mode)
                            M_WR: state_nxt = S_WRITE;
                            M_RD: begin
                                tx_nxt    = rd_word(rx_word[7:0]);
                                state_nxt = S_READ;
                            end
                            default: if (QUAD_DUMMY == 0) begin
                                tx_nxt    = rd_word(rx_word[7:0]);
                                state_nxt = S_QREAD;
                            end else begin
                                state_nxt = S_DUMMY;
                            end
                        endcase
                    end
                end
                S_DUMMY: if (rise) begin
                    cnt_nxt = bit_cnt + 8'd1;
                    if (bit_cnt == 8'(QUAD_DUMMY - 1)) begin
                        cnt_nxt   = '0;
                        tx_nxt    = rd_word(ptr);
                        state_nxt = S_QREAD;
                    end
                end
                S_WRITE: if (rise) begin
                    rx_nxt  = rx_word;
                    cnt_nxt = bit_cnt + 8'd1;
                    if (bit_cnt == 8'(DATA_W - 1)) begin
                        cnt_nxt = '0;
                        commit  = 1'b1;
                        ptr_nxt = ptr_inc(ptr);
                    end
                end
                S_READ: if (fall) begin
                    miso_nxt = tx_sh[DATA_W-1];
                    tx_nxt   = {tx_sh[DATA_W-2:0], 1'b0};
                    cnt_nxt  = bit_cnt + 8'd1;
                    if (bit_cnt == 8'(DATA_W - 1)) begin
                        cnt_nxt = '0;
                        ptr_nxt = ptr_inc(ptr);
                        tx_nxt  = rd_word(ptr_inc(ptr));
                    end
                end
                S_QREAD: if (fall) begin
                    qd_nxt  = tx_sh[DATA_W-1 -: 4];
                    tx_nxt  = {tx_sh[DATA_W-5:0], 4'b0000};
                    cnt_nxt = bit_cnt + 8'd1;
                    if (bit_cnt == 8'(DATA_W / 4 - 1)) begin
                        cnt_nxt = '0;
                        ptr_nxt = ptr_inc(ptr);
                        tx_nxt  = rd_word(ptr_inc(ptr));
                    end
                end
                default: ;
            endcase
        end
        // Data lines are quiet outside the state that owns them.
        if (state_nxt != S_READ)  miso_nxt = 1'b0;
        if (state_nxt != S_QREAD) qd_nxt   = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mode       <= M_WR;
            bit_cnt    <= '0;
            ptr        <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            miso_r     <= 1'b0;
            qd_r       <= '0;
            q_oe_r     <= '0;
            regs       <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            debug_data <= '0;
            // A frame already in flight must be deselected before it is parsed again.
            need_desel <= ~desel;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            bit_cnt    <= cnt_nxt;
            ptr        <= ptr_nxt;
            rx_sh      <= rx_nxt;
            tx_sh      <= tx_nxt;
            miso_r     <= miso_nxt;
            qd_r       <= qd_nxt;
            q_oe_r     <= (state_nxt == S_READ)  ? 4'b0010 :
                          (state_nxt == S_QREAD) ? 4'b1111 : 4'b0000;
            need_desel <= need_desel & ~desel;
            wr_strobe  <= commit;
            if (commit) begin
                wr_addr <= ADDR_W'(ptr);
                if (32'(ptr) < 32'(NUM_REGS)) regs[ptr[IW-1:0]] <= rx_word;
            end
            debug_data <= (32'(debug_addr) < 32'(NUM_REGS)) ? regs[debug_addr[IW-1:0]] : '0;
        end
    end

    assign bus.spi_miso       = miso_r;
    assign bus.spi_q_data_out = qd_r;
    assign bus.spi_q_oe       = q_oe_r;
endmodule

// File: tb/tb_spi_reg_peri.sv
// Bench for spi_reg_peri: an SPI master task drives frames; expected write
// addresses and read words are queued and checked by independent monitors.
module tb_spi_reg_peri;
    localparam int DATA_W = 8, NUM_REGS = 16, ADDR_W = 4, QUAD_DUMMY = 2;
    localparam time HALF = 80ns;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_data;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;

    spi_reg_peri_if bus ();

    spi_reg_peri #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
                   .QUAD_DUMMY(QUAD_DUMMY)) dut (
        .clk(clk), .rst(rst), .bus(bus), .debug_addr(debug_addr),
        .debug_data(debug_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr));

    always #5ns clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W-1:0] exp_wr[$];
    logic [7:0]        exp_rd[$];
    logic              obs_any;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the next queued address.
    always @(negedge clk) begin
        if (wr_strobe) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_strobe: unexpected pulse at wr_addr=%0d", wr_addr);
            end else begin
                check("wr_addr", 32'(wr_addr), 32'(exp_wr.pop_front()));
            end
        end
    end

    // Read monitor: samples on SCLK rise like a master, whenever outputs are enabled.
    int         rd_bits = 0;
    logic [7:0] rd_acc  = '0;
    always @(posedge bus.spi_clk or posedge bus.spi_select) begin
        if (bus.spi_select) begin
            rd_bits = 0;
        end else if (bus.spi_q_oe == 4'b0010) begin
            rd_acc  = {rd_acc[6:0], bus.spi_miso};
            rd_bits += 1;
        end else if (bus.spi_q_oe == 4'b1111) begin
            rd_acc  = {rd_acc[3:0], bus.spi_q_data_out};
            rd_bits += 4;
        end
        if (rd_bits == 8) begin
            rd_bits = 0;
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_word: unexpected word 0x%0h", rd_acc);
            end else begin
                check("rd_word", 32'(rd_acc), 32'(exp_rd.pop_front()));
            end
        end
    end

    task automatic spi_bit(input logic m);
        bus.spi_mosi = m;
        #(HALF);
        bus.spi_clk = 1'b1;
        obs_any = obs_any | bus.spi_miso | (|bus.spi_q_oe) | (|bus.spi_q_data_out);
        #(HALF);
        bus.spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame_start();
        @(negedge clk);
        bus.spi_select = 1'b0;
        #(HALF);
    endtask

    task automatic frame_end();
        #(HALF);
        bus.spi_select = 1'b1;
        #(4 * HALF);
        @(negedge clk);
    endtask

    task automatic dbg_check(input int a, input logic [7:0] exp, input string name);
        @(negedge clk);
        debug_addr = ADDR_W'(a);
        @(negedge clk);
        check(name, 32'(debug_data), 32'(exp));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_select = 1'b1;
        bus.spi_mosi = 1'b0;
        debug_addr = '0;
        obs_any = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst spi_miso", 32'(bus.spi_miso), 32'd0);
        check("rst q_data",   32'(bus.spi_q_data_out), 32'd0);
        check("rst q_oe",     32'(bus.spi_q_oe), 32'd0);
        check("rst wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst wr_addr",  32'(wr_addr), 32'd0);
        for (int a = 0; a < NUM_REGS; a++) dbg_check(a, 8'h00, "rst debug_data");

        // Burst write across the top of the file
        exp_wr.push_back(4'd14); exp_wr.push_back(4'd15); exp_wr.push_back(4'd0);
        frame_start();
        spi_byte(8'h02); spi_byte(8'h0E);
        spi_byte(8'hA5); spi_byte(8'h3C); spi_byte(8'h77);
        frame_end();
        dbg_check(15, 8'h3C, "debug reg15");
        dbg_check(14, 8'hA5, "debug reg14");
        dbg_check(0,  8'h77, "debug reg0 wrap");

        // Single read, two words
        exp_rd.push_back(8'hA5); exp_rd.push_back(8'h3C);
        frame_start();
        spi_byte(8'h03); spi_byte(8'h0E);
        spi_bit(1'b0);
        check("read q_oe", 32'(bus.spi_q_oe), 32'h2);
        for (int i = 0; i < 15; i++) spi_bit(1'b0);
        frame_end();
        check("q_oe after read", 32'(bus.spi_q_oe), 32'h0);

        // Quad read with dummy cycles
        exp_rd.push_back(8'h3C); exp_rd.push_back(8'h77);
        frame_start();
        spi_byte(8'h6B); spi_byte(8'h0F);
        for (int i = 0; i < QUAD_DUMMY; i++) spi_bit(1'b0);
        spi_bit(1'b0);
        check("qread q_oe", 32'(bus.spi_q_oe), 32'hF);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        frame_end();
        check("q_oe after qread", 32'(bus.spi_q_oe), 32'h0);

        // Aborted write leaves the old value
        exp_wr.push_back(4'd1);
        frame_start();
        spi_byte(8'h02); spi_byte(8'h01); spi_byte(8'h5A);
        frame_end();
        frame_start();
        spi_byte(8'h02); spi_byte(8'h01);
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        frame_end();
        dbg_check(1, 8'h5A, "debug reg1 after abort");
        exp_rd.push_back(8'h5A);
        frame_start();
        spi_byte(8'h03); spi_byte(8'h01);
        for (int i = 0; i < 8; i++) spi_bit(1'b0);
        frame_end();

        // Unknown command: everything silent
        frame_start();
        spi_byte(8'h9F);
        obs_any = 1'b0;
        spi_byte(8'h02); spi_byte(8'h0E);
        check("ignore outputs", 32'(obs_any), 32'd0);
        frame_end();
        dbg_check(14, 8'hA5, "debug reg14 after ignore");

        // Reset mid-frame: rest of the frame must not be parsed
        frame_start();
        spi_byte(8'h02); spi_byte(8'h03);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk); rst = 1'b0;
        spi_byte(8'h02); spi_byte(8'h04); spi_byte(8'h11);
        frame_end();
        dbg_check(4,  8'h00, "debug reg4 after reset frame");
        dbg_check(14, 8'h00, "debug reg14 cleared by reset");
        exp_rd.push_back(8'h00);
        frame_start();
        spi_byte(8'h03); spi_byte(8'h04);
        for (int i = 0; i < 8; i++) spi_bit(1'b0);
        frame_end();
        exp_wr.push_back(4'd5);
        frame_start();
        spi_byte(8'h02); spi_byte(8'h05); spi_byte(8'hC3);
        frame_end();
        dbg_check(5, 8'hC3, "debug reg5 after reselect");

        repeat (4) @(negedge clk);
        check("wr queue drained", 32'(exp_wr.size()), 32'd0);
        check("rd queue drained", 32'(exp_rd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_reg_peri.md
# spi_reg_peri

Parametrised SPI-slave register-file peripheral, the next generation of the team's SPI peripheral. It oversamples an external SPI bus on the system clock. It decodes single-byte commands with an address byte and serves a NUM_REGS × DATA_W register file with auto-incrementing burst reads and writes. Reads are available in single-bit (MISO) or quad-output mode. A registered debug port exposes any register to the chip's other logic, such as the 7-segment/debug mux.

## Interface
Parameters:
- `DATA_W`, 8: register width; must be 8, 16 or 32.
- `NUM_REGS`, 16: register count; must be 2..256.
- `ADDR_W`, 4: debug address width; must be ≥ clog2(NUM_REGS).
- `QUAD_DUMMY`, 2: dummy SCLK cycles between the address byte and quad read data.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `spi_clk` input 1: SPI SCLK, mode 0; asynchronous to `clk`.
- `spi_select` input 1: chip select, active-low; asynchronous.
- `spi_mosi` input 1: SPI data in; asynchronous.
- `spi_miso` output 1: single-bit read data.
- `spi_q_data_out` output 4: quad read data; bit 3 is the MSB nibble bit.
- `spi_q_oe` output 4: output enables for the quad lines; single mode drives 4'b0010 only.
- `debug_addr` input ADDR_W: debug read index.
- `debug_data` output DATA_W: registered value of reg[`debug_addr`].
- `wr_strobe` output 1: 1-cycle pulse when a register write commits.
- `wr_addr` output ADDR_W: index of the committed write; valid with `wr_strobe`.

## Operation
- **Input synchronisation:** `spi_clk`, `spi_select` and `spi_mosi` each pass through 2-flop synchronisers.
- **Edge detection:** a third flop on SCLK gives `rise`/`fall` pulses.
- **Clock ratio:** the `clk` frequency must be ≥ 4× the SCLK frequency.
- **MOSI sampling:** MOSI is sampled on `rise`.
- **Output update:** MISO and quad outputs update on `fall`.
- **Bit order:** MSB first.
- **FSM states:**
  - IDLE: selected → CMD (bit counter = 0).
  - CMD: after 8 bits, decode the command.
    - 0x02 → ADDR(write).
    - 0x03 → ADDR(read).
    - 0x6B → ADDR(qread).
    - Anything else → IGNORE.
  - ADDR: after 8 bits, latch `ptr` = the address byte.
    - Write → WRITE.
    - Read → load shift register, → READ.
    - Qread → DUMMY, or → QREAD if `QUAD_DUMMY` = 0.
  - DUMMY: count `QUAD_DUMMY` rising edges, then load shift register, → QREAD.
  - WRITE: shift in DATA_W bits, then commit reg[`ptr`], pulse `wr_strobe`, `ptr`++; stay in WRITE.
  - READ: shift out 1 bit per `fall`. After DATA_W bits, reload the shift register from reg[`ptr`+1] and `ptr`++.
  - QREAD: shift out 4 bits per `fall`. Reload after DATA_W/4 clocks; `ptr`++.
  - IGNORE: outputs 0, `spi_q_oe` = 0, until deselect.
- **Deselect:** a synchronised `spi_select` = 1 in any state → IDLE on the next `clk`.
  - Bit counter cleared.
  - A partial write word is discarded, with no `wr_strobe`.
  - `spi_q_oe` goes to 0.
- **Auto-increment:** `ptr` wraps from NUM_REGS-1 to 0. With NUM_REGS = 256 this is the natural 8-bit wrap.
- **Out-of-range address** (`ptr` ≥ NUM_REGS):
  - Writes are dropped; `wr_strobe` still pulses, with `wr_addr` = `ptr`[ADDR_W-1:0].
  - Reads return 0.
  - The pointer wraps to 0 after NUM_REGS-1 only. An out-of-range start address increments until 255, then wraps to 0.
- **Output enables during reads:**
  - READ: `spi_q_oe` = 4'b0010.
  - QREAD: `spi_q_oe` = 4'b1111.
  - All other states: 4'b0000.
- **Debug port:** `debug_data` <= reg[`debug_addr`] every cycle. Out-of-range `debug_addr` gives 0.

## Timing
- **Reset values:** every register-file entry 0, `ptr` 0, FSM IDLE. `spi_miso` 0, `spi_q_data_out` 0, `spi_q_oe` 0, `debug_data` 0, `wr_strobe` 0, `wr_addr` 0.
- **Input latency:** pad to `rise`/`fall` pulse takes 3 `clk` cycles.
- **Read data launch:** the first read bit is driven on the `fall` that follows the last address `rise`, or the last dummy `rise`. The master samples it on the next SCLK rising edge.
- **Write commit:** happens on the `clk` after the `rise` that delivers the word's LSB. `wr_strobe` is high for exactly 1 cycle.
- **Debug latency:** 1 cycle.
- **Same-cycle debug read and SPI commit:** `debug_data` shows the old value that cycle and the new value on the next.
- **Reset during a transfer:** FSM goes to IDLE.
  - The remainder of the frame is ignored until deselect, then reselect.
  - The bus is not re-parsed while `spi_select` stays low after `rst` deasserts. A sticky "need-deselect" flag is set by reset only if selected.

## Test plan
- Reset, then hold idle: all outputs 0, `spi_q_oe` = 0; `debug_data` = 0 for every `debug_addr`.
- Write burst (DATA_W = 8): cmd 0x02, addr 0x0E, data 0xA5, 0x3C, 0x77.
  - reg14 = 0xA5, reg15 = 0x3C, reg0 = 0x77 (wrap).
  - Three `wr_strobe` pulses with `wr_addr` 14, 15, 0.
  - `debug_addr` = 15 gives 0x3C one cycle later.
- Single read: after the write burst, cmd 0x03, addr 0x0E, 16 clocks.
  - MISO returns 0xA5 then 0x3C.
  - `spi_q_oe` = 0010 during data, 0000 after deselect.
- Quad read (`QUAD_DUMMY` = 2): cmd 0x6B, addr 0x0F, 2 dummy clocks, 4 data clocks.
  - Nibbles 0x3, 0xC, 0x7, 0x7.
  - `spi_q_oe` = 1111 during data.
- Aborted write: cmd 0x02, addr 0x01, 5 data bits, then deselect.
  - reg1 unchanged, no `wr_strobe`.
  - The next frame (cmd 0x03, addr 0x01) reads the old value.
- Unknown command 0x9F followed by 16 clocks: no writes, MISO 0, `spi_q_oe` 0. Reset asserted mid-frame is ignored until reselect.
